fft_frame_buffer: RTL and testbench

Sits directly downstream of `xadc_oversample256` and converts its oversampled stream into overlapping frames for the FFT core. It stores each sample qualified by the `done` strobe in a circular RAM and converts each sample from unipolar offset-binary to two's complement. Every `HOP` samples it streams the most recent `2^ADDR_W` samples, oldest first, on a ready/valid master port with `tlast`.

---
 rtl/fft_frame_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_fft_frame_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
//
// Turns the oversampled XADC stream into overlapping frames for the FFT core.
// Every strobed sample is converted from unipolar offset-binary to two's
// complement and written into a circular RAM of depth 2N (N = 2^ADDR_W).
// After the first N samples, and then every HOP samples, the most recent N
// samples are streamed oldest-first on an AXI-Stream style master port.
//
// Ports:
//   clk          - single clock, all registers on rising edge
//   reset        - synchronous, active-high; returns everything to FILL
//   sample_in    - raw unsigned 16-bit sample
//   sample_valid - one-cycle strobe qualifying sample_in
//   m_tdata      - signed sample word (registered)
//   m_tvalid     - m_tdata/m_tlast hold a word (registered)
//   m_tready     - downstream accepts the word this cycle
//   m_tlast      - marks word N-1 of a frame (registered)
//   overrun      - sticky: a frame trigger was dropped while streaming
//   frame_count  - frames completed (tlast handshakes), wraps at 16 bits
//   o_dbg_state  - current FSM state (FILL=0, IDLE=1, STREAM=2)
//
// Handshake: a word transfers on any rising edge where m_tvalid and m_tready
// are both high. Once m_tvalid is raised it stays high, with m_tdata and
// m_tlast unchanged, until that transfer happens; only reset may drop it.
// ---------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int ADDR_W = 10,
    parameter int HOP    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        overrun,
    output logic [15:0] frame_count,
    output logic [1:0]  o_dbg_state
);

    localparam int PW = ADDR_W + 1;
    localparam int N  = 1 << ADDR_W;

    localparam logic [PW-1:0] N_P      = PW'(N);
    localparam logic [PW-1:0] N_LAST   = PW'(N - 1);
    localparam logic [PW-1:0] HOP_LAST = PW'(HOP - 1);
    localparam logic [PW-1:0] ONE_P    = PW'(1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_IDLE   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Sample storage: twice the frame length so a frame being read and the
    // next N writes never touch the same address.
    logic [15:0]   r_mem [0:2*N-1];

    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_fill_cnt;
    logic [PW-1:0] r_hop_cnt;
    logic [PW-1:0] r_words_left;

    // Two-entry output queue: r_out_* drives the port, r_skid_* catches the
    // word already read from RAM when the port stalls.
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_last;
    logic          r_skid_valid;
    logic [15:0]   r_skid_data;
    logic          r_skid_last;

    logic          r_overrun;
    logic [15:0]   r_frame_count;

    logic [15:0]   w_sample_conv;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_start;
    logic          w_pop;
    logic          w_frame_done;
    logic          w_fill_trig;
    logic          w_hop_trig;
    logic          w_trigger;
    logic          w_accept;
    logic          w_room;
    logic          w_issue;
    logic          w_issue_last;
    logic [15:0]   w_rd_word;

    // Offset-binary to two's complement is just an MSB flip.
    assign w_sample_conv = {~sample_in[15], sample_in[14:0]};
    assign w_wr_next     = r_wr_ptr + ONE_P;
    // Oldest sample of the frame ending with the sample written this cycle.
    assign w_rd_start    = w_wr_next - N_P;

    assign w_pop         = r_out_valid & m_tready;
    assign w_frame_done  = w_pop & r_out_last;

    assign w_fill_trig   = (r_state == S_FILL) & sample_valid & (r_fill_cnt == N_LAST);
    assign w_hop_trig    = (r_state != S_FILL) & sample_valid & (r_hop_cnt == HOP_LAST);
    assign w_trigger     = w_fill_trig | w_hop_trig;
    // A trigger landing on the final handshake starts the next frame at once.
    assign w_accept      = w_trigger & ((r_state != S_STREAM) | w_frame_done);

    // Issue a read only if the queue will have a free slot after this
    // cycle's pop; the skid entry is only ever occupied when out is.
    assign w_room        = ~r_skid_valid | w_pop;
    assign w_issue       = (r_state == S_STREAM) & (r_words_left != '0) & w_room;
    assign w_issue_last  = (r_words_left == ONE_P);
    assign w_rd_word     = r_mem[r_rd_ptr];

    // RAM write port: every strobed sample is stored, in every state.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            r_mem[r_wr_ptr] <= w_sample_conv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_hop_cnt     <= '0;
            r_words_left  <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_data   <= '0;
            r_skid_last   <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (sample_valid) begin
                r_wr_ptr <= w_wr_next;
                if (r_state == S_FILL) begin
                    r_fill_cnt <= r_fill_cnt + ONE_P;
                end else if (w_hop_trig) begin
                    // Reset on dropped triggers too, keeping frames HOP-aligned.
                    r_hop_cnt <= '0;
                end else begin
                    r_hop_cnt <= r_hop_cnt + ONE_P;
                end
            end

            if (w_trigger & ~w_accept) begin
                r_overrun <= 1'b1;
            end

            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_issue) begin
                r_rd_ptr     <= r_rd_ptr + ONE_P;
                r_words_left <= r_words_left - ONE_P;
            end

            if (w_accept) begin
                r_rd_ptr     <= w_rd_start;
                r_words_left <= N_P;
                r_state      <= S_STREAM;
            end else if (w_frame_done) begin
                r_state      <= S_IDLE;
            end

            if (w_pop) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_out_valid <= 1'b1;
                    if (w_issue) begin
                        r_skid_data  <= w_rd_word;
                        r_skid_last  <= w_issue_last;
                    end else begin
                        r_skid_valid <= 1'b0;
                    end
                end else begin
                    r_out_valid <= w_issue;
                    if (w_issue) begin
                        r_out_data <= w_rd_word;
                        r_out_last <= w_issue_last;
                    end
                end
            end else if (w_issue) begin
                if (r_out_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_rd_word;
                    r_skid_last  <= w_issue_last;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_rd_word;
                    r_out_last  <= w_issue_last;
                end
            end
        end
    end

    assign m_tdata     = r_out_data;
    assign m_tvalid    = r_out_valid;
    assign m_tlast     = r_out_last;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;

    localparam int ADDR_W = 4;
    localparam int N      = 16;
    localparam int HOP    = 8;
    localparam int GAP    = 10;

    // ---------------- clock / reset block ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        overrun;
    logic [15:0] frame_count;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fft_frame_buffer #(.ADDR_W(ADDR_W), .HOP(HOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .overrun      (overrun),
        .frame_count  (frame_count),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];        // {tlast, tdata}
    logic [15:0] hist[$];         // converted samples since reset
    bit          model_busy = 0;
    bit          exp_overrun = 0;
    bit          bp_en = 0;
    int          words_popped = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_sample(input logic [15:0] raw);
        int k;
        @(negedge clk);
        sample_in    = raw;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        hist.push_back({~raw[15], raw[14:0]});
        k = hist.size();
        if (k == N || (k > N && ((k - N) % HOP) == 0)) begin
            if (model_busy) begin
                exp_overrun = 1'b1;
            end else begin
                model_busy = 1'b1;
                for (int j = 0; j < N; j++) begin
                    exp_q.push_back({(j == N - 1), hist[k - N + j]});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bp_en) m_tready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic feed(input logic [15:0] raw);
        drive_sample(raw);
        idle(GAP - 2);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !m_tvalid) break;
            idle(1);
        end
        checks++;
        assert (exp_q.size() == 0 && m_tvalid === 1'b0) else begin
            errors++;
            $error("FAIL %s observed=%0d_words_pending expected=0_pending", tag, exp_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- output monitor ----------------
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_tvalid, 1);
                    check("hold_data", m_tdata, prev_data);
                    check("hold_last", m_tlast, prev_last);
                end
                if (m_tvalid && m_tready) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL extra_word observed=0x%0h expected=no_word", m_tdata);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("word_data", m_tdata, e[15:0]);
                        check("word_last", m_tlast, e[16]);
                        words_popped++;
                        if (m_tlast) model_busy = 1'b0;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        m_tready     = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Fill and first frame: 0x8000+i converts to i.
        for (int i = 0; i < 15; i++) feed(16'h8000 + 16'(i));
        drive_sample(16'h800F);
        check("lat_t1_tvalid", m_tvalid, 0);
        @(negedge clk);
        check("lat_t2_tvalid", m_tvalid, 1);
        for (int j = 1; j < N; j++) begin
            @(negedge clk);
            check("burst_tvalid", m_tvalid, 1);
        end
        check("burst_end_tlast", m_tlast, 1);
        @(negedge clk);
        check("after_frame_tvalid", m_tvalid, 0);
        wait_drained("drain_f1", 40);
        check("f1_frame_count", frame_count, 1);
        check("f1_state_idle", dbg_state, 1);

        // Hop overlap.
        for (int i = 16; i < 24; i++) feed(16'h8000 + 16'(i));
        wait_drained("drain_f2", 40);
        check("f2_frame_count", frame_count, 2);
        check("f2_overrun", overrun, exp_overrun);

        // Sign conversion extremes.
        feed(16'h0000);
        feed(16'hFFFF);
        for (int i = 0; i < 6; i++) feed(16'($urandom_range(0, 65535)));
        wait_drained("drain_f3", 40);
        check("f3_frame_count", frame_count, 3);

        // Backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < HOP; i++) feed(16'($urandom_range(0, 65535)));
        idle(80);
        bp_en    = 1'b0;
        m_tready = 1'b1;
        wait_drained("drain_f4", 80);
        check("f4_frame_count", frame_count, 4);
        check("f4_overrun", overrun, exp_overrun);

        // Overrun: stall across the next hop boundary.
        for (int i = 0; i < HOP - 1; i++) feed(16'($urandom_range(0, 65535)));
        drive_sample(16'($urandom_range(0, 65535)));
        m_tready = 1'b0;
        idle(GAP - 2);
        for (int i = 0; i < 9; i++) feed(16'($urandom_range(0, 65535)));
        check("ovr_set", overrun, exp_overrun);
        check("ovr_stalled_tvalid", m_tvalid, 1);
        m_tready = 1'b1;
        wait_drained("drain_f5", 60);
        check("f5_frame_count", frame_count, 5);
        idle(20);
        check("ovr_no_extra_frame", frame_count, 5);
        for (int i = 0; i < HOP - 2; i++) feed(16'($urandom_range(0, 65535)));
        drive_sample(16'($urandom_range(0, 65535)));
        wait_drained("drain_f6", 40);
        check("f6_frame_count", frame_count, 6);
        check("f6_overrun_sticky", overrun, exp_overrun);

        // Reset mid-frame.
        for (int i = 0; i < HOP - 1; i++) feed(16'($urandom_range(0, 65535)));
        base = words_popped;
        drive_sample(16'($urandom_range(0, 65535)));
        for (int i = 0; i < 40; i++) begin
            if (words_popped >= base + 6) break;
            @(negedge clk);
        end
        checks++;
        assert (words_popped >= base + 6) else begin
            errors++;
            $error("FAIL midframe_words observed=%0d expected=6", words_popped - base);
        end
        reset = 1'b1;
        exp_q.delete();
        hist.delete();
        model_busy  = 1'b0;
        exp_overrun = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;
        for (int i = 0; i < N; i++) feed(16'($urandom_range(0, 65535)));
        wait_drained("drain_f7", 40);
        check("f7_frame_count", frame_count, 1);
        check("f7_overrun", overrun, exp_overrun);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
